// File: rtl/tt_extract7.sv
//------------------------------------------------------------------------------
// tt_extract7 : sweeps all 128 minterms of a 7-input function and captures its
// truth table. Optional self_dual output via `TT_EXTRACT7_SELFDUAL_EN.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tt_extract7 #(
  parameter int SETTLE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [6:0]   x,
  input  logic         f,
  output logic         busy,
  output logic         tt_valid,
  input  logic         tt_ready,
  output logic [127:0] tt,
  output logic [7:0]   ones
`ifdef TT_EXTRACT7_SELFDUAL_EN
  ,
  output logic         self_dual
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [6:0] k;
  logic [3:0] sub;
  logic       sample;

  // f is captured on the last cycle of each minterm's hold window
  assign sample = (state == S_SCAN) && (sub == SETTLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SCAN;
      S_SCAN:  if (sample && (k == 7'd127)) state_nx = S_OUT;
      S_OUT:   if (tt_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    tt_valid = 1'b0;
    x        = 7'd0;
    case (state)
      S_SCAN: begin
        busy = 1'b1;
        x    = k;
      end
      S_OUT:   tt_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k    <= 7'd0;
      sub  <= 4'd0;
      tt   <= '0;
      ones <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k    <= 7'd0;
            sub  <= 4'd0;
            tt   <= '0;
            ones <= 8'd0;
          end
        end
        S_SCAN: begin
          if (sample) begin
            tt[k] <= f;
            ones  <= ones + {7'd0, f};
            k     <= k + 7'd1;
            sub   <= 4'd0;
          end else begin
            sub <= sub + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TT_EXTRACT7_SELFDUAL_EN
  logic [63:0] mirror_diff;

  for (genvar i = 0; i < 64; i++) begin : g_mirror
    assign mirror_diff[i] = tt[i] ^ tt[127-i];
  end

  // tt is cleared on reset and start, so this is 0 then and follows tt otherwise
  assign self_dual = &mirror_diff;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tt_extract7.sv
//------------------------------------------------------------------------------
// tb_tt_extract7 : randomized bench for tt_extract7 (SETTLE=0 and SETTLE=3).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tt_extract7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         tt_ready;
  logic         sel;
  logic [127:0] lut;

  logic         start_a, start_b, rdy_a, rdy_b;
  logic [6:0]   x_a, x_b;
  logic         f_a, f_b;
  logic         busy_a, busy_b, val_a, val_b;
  logic [127:0] tt_a, tt_b;
  logic [7:0]   ones_a, ones_b;

  logic [6:0]   cur_x;
  logic         cur_busy, cur_valid;
  logic [127:0] cur_tt;
  logic [7:0]   cur_ones;

  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_tt;
  logic [7:0]   exp_ones;
  logic         exp_sd;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign rdy_a   = tt_ready & ~sel;
  assign rdy_b   = tt_ready & sel;
  assign f_a     = lut[x_a];
  assign f_b     = lut[x_b];

  assign cur_x     = sel ? x_b    : x_a;
  assign cur_busy  = sel ? busy_b : busy_a;
  assign cur_valid = sel ? val_b  : val_a;
  assign cur_tt    = sel ? tt_b   : tt_a;
  assign cur_ones  = sel ? ones_b : ones_a;

`ifdef TT_EXTRACT7_SELFDUAL_EN
  logic sd_a, sd_b, cur_sd;
  assign cur_sd = sel ? sd_b : sd_a;
`endif

  tt_extract7 #(.SETTLE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x(x_a), .f(f_a),
    .busy(busy_a), .tt_valid(val_a), .tt_ready(rdy_a), .tt(tt_a), .ones(ones_a)
`ifdef TT_EXTRACT7_SELFDUAL_EN
    , .self_dual(sd_a)
`endif
  );

  tt_extract7 #(.SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x(x_b), .f(f_b),
    .busy(busy_b), .tt_valid(val_b), .tt_ready(rdy_b), .tt(tt_b), .ones(ones_b)
`ifdef TT_EXTRACT7_SELFDUAL_EN
    , .self_dual(sd_b)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_sd(input string tag, input logic exp);
`ifdef TT_EXTRACT7_SELFDUAL_EN
    check(tag, 128'(cur_sd), 128'(exp));
`endif
  endtask

  function automatic logic [7:0] count_ones(input logic [127:0] v);
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(v[i]);
    return 8'(n);
  endfunction

  // f(~x) = ~f(x) for every x
  function automatic logic is_self_dual(input logic [127:0] v);
    for (int i = 0; i < 128; i++)
      if (v[i] == v[(~i) & 127]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [127:0] rand_lut();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full scan from IDLE; ends at the first negedge with tt_valid expected high
  task automatic run_scan(input logic which, input logic [127:0] table_in, input bit noisy);
    int hold = which ? 4 : 1;
    int lat  = 128 * hold;
    sel      = which;
    lut      = table_in;
    exp_tt   = table_in;
    exp_ones = count_ones(table_in);
    exp_sd   = is_self_dual(table_in);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n <= lat; n++) begin
      if (n < lat)
        check("scan_state", 128'({cur_busy, cur_valid, cur_x}), 128'({1'b1, 1'b0, 7'(n / hold)}));
      else
        check("out_state", 128'({cur_busy, cur_valid, cur_x}), 128'({1'b0, 1'b1, 7'd0}));
      if (n < lat) begin
        start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        tt_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
    end
    start    = 1'b0;
    tt_ready = 1'b0;
    check("tt", cur_tt, exp_tt);
    check("ones", 128'(cur_ones), 128'(exp_ones));
    check_sd("self_dual", exp_sd);
  endtask

  task automatic accept(input int hold, input bit with_start);
    for (int i = 0; i < hold; i++) begin
      tt_ready = 1'b0;
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_state", 128'({cur_busy, cur_valid, cur_x}), 128'({1'b0, 1'b1, 7'd0}));
      check("hold_tt", cur_tt, exp_tt);
    end
    tt_ready = 1'b1;
    start    = with_start;
    @(negedge clk);
    tt_ready = 1'b0;
    start    = 1'b0;
    check("ack_state", 128'({cur_busy, cur_valid, cur_x}), 128'(0));
    check("ack_tt", cur_tt, exp_tt);
    check("ack_ones", 128'(cur_ones), 128'(exp_ones));
    check_sd("ack_self_dual", exp_sd);
    repeat (3) @(negedge clk);
    check("idle_state", 128'({cur_busy, cur_valid, cur_x}), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] t;
    rst_n    = 1'b0;
    start    = 1'b0;
    tt_ready = 1'b0;
    sel      = 1'b0;
    lut      = '0;
    #1;
    check("rst_a", {x_a, busy_a, val_a, ones_a, tt_a[104:0]}, 128'(0));
    check("rst_a_tt", tt_a, 128'(0));
    check("rst_b", {x_b, busy_b, val_b, ones_b, tt_b[104:0]}, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // majority(x0,x1,x2)
    for (int k = 0; k < 128; k++) t[k] = (((k & 1) + ((k >> 1) & 1) + ((k >> 2) & 1)) >= 2);
    run_scan(1'b0, t, 1'b0);
    check("maj_tt_const", cur_tt, {16{8'hE8}});
    check("maj_ones_const", 128'(cur_ones), 128'(64));
    check_sd("maj_sd_const", 1'b1);
    accept(0, 1'b0);

    // AND of all seven inputs
    for (int k = 0; k < 128; k++) t[k] = (k == 127);
    run_scan(1'b0, t, 1'b0);
    check("and7_tt_const", cur_tt, {1'b1, 127'd0});
    check("and7_ones_const", 128'(cur_ones), 128'(1));
    check_sd("and7_sd_const", 1'b0);
    accept(0, 1'b0);

    // constant 1 with a long stall, then constant 0 acked together with start
    run_scan(1'b0, {128{1'b1}}, 1'b0);
    check("one_ones_const", 128'(cur_ones), 128'(8'h80));
    check_sd("one_sd_const", 1'b0);
    accept(20, 1'b0);
    run_scan(1'b0, 128'd0, 1'b0);
    check("zero_ones_const", 128'(cur_ones), 128'(0));
    accept(0, 1'b1);

    // SETTLE=3, f = x0, start/ready noise during the scan
    for (int k = 0; k < 128; k++) t[k] = k[0];
    run_scan(1'b1, t, 1'b1);
    check("x0_tt_const", cur_tt, {32{4'hA}});
    accept(2, 1'b1);

    // random functions on both instances, including one forced self-dual
    for (int r = 0; r < 4; r++) begin
      t = rand_lut();
      if (r == 1) for (int k = 0; k < 64; k++) t[127-k] = ~t[k];
      run_scan(1'(r & 1), t, 1'b1);
      accept($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // reset while the scan is at minterm 60
    sel   = 1'b0;
    lut   = {128{1'b1}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("pre_rst_x", 128'(cur_x), 128'(60));
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 128'({busy_a, val_a, x_a, ones_a}), 128'(0));
    check("mid_rst_tt", tt_a, 128'(0));
    check_sd("mid_rst_sd", 1'b0);
    @(negedge clk);
    check("rst_hold", 128'({busy_a, val_a, x_a}), 128'(0));
    rst_n = 1'b1;
    run_scan(1'b0, rand_lut(), 1'b0);
    accept(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
